// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline-control types, MDU timing defaults and hazard helpers
package cpu_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } hz_state_t;

    localparam int MDU_LATENCY_DEF = 4;
    localparam int MDU_CNT_W       = 4;

    // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard status inputs and stall/flush control outputs
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_RS_i;
    logic [4:0]       IF_ID_RT_i;
    logic [4:0]       ID_EX_RT_i;
    logic             ID_EX_MemRead_i;
    logic             branch_taken_i;
    logic             mdu_start_i;
    logic             mem_stall_i;
    logic             stall_cnt_clr_i;
    logic             PC_write_o;
    logic             IF_ID_write_o;
    logic             IF_ID_flush_o;
    logic             ID_EX_bubble_o;
    logic             EX_hold_o;
    logic             MEM_hold_o;
    logic             busy_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output IF_ID_RS_i, IF_ID_RT_i, ID_EX_RT_i, ID_EX_MemRead_i,
               branch_taken_i, mdu_start_i, mem_stall_i, stall_cnt_clr_i,
        input  PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
               EX_hold_o, MEM_hold_o, busy_o, stall_cnt_o
    );

    modport slave (
        input  IF_ID_RS_i, IF_ID_RT_i, ID_EX_RT_i, ID_EX_MemRead_i,
               branch_taken_i, mdu_start_i, mem_stall_i, stall_cnt_clr_i,
        output PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
               EX_hold_o, MEM_hold_o, busy_o, stall_cnt_o
    );

endinterface

// File: rtl/mdu_timer.sv
// rtl/mdu_timer.sv - RUN/MDU_BUSY sequencer with a pausable hold down-counter
module mdu_timer
    import cpu_pkg::*;
#(
    parameter int LATENCY = MDU_LATENCY_DEF
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      start_i,
    input  logic      pause_i,
    output hz_state_t state_o,
    output logic      busy_o
);

    localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(LATENCY - 1);

    logic [MDU_CNT_W-1:0] mdu_cnt;

    // The issue cycle is itself a hold cycle, so only LATENCY-1 further cycles are counted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_o <= ST_RUN;
            mdu_cnt <= '0;
            busy_o  <= 1'b0;
        end else if (state_o == ST_RUN) begin
            if (start_i && !pause_i && (LATENCY > 1)) begin
                state_o <= ST_MDU_BUSY;
                mdu_cnt <= CNT_LOAD;
                busy_o  <= 1'b1;
            end
        end else if (!pause_i) begin
            if (mdu_cnt == MDU_CNT_W'(1)) begin
                state_o <= ST_RUN;
                mdu_cnt <= '0;
                busy_o  <= 1'b0;
            end else begin
                mdu_cnt <= mdu_cnt - MDU_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - prioritised stall, bubble, flush and hold control with stall counter
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF,
    parameter int CNT_W       = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    hazard_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_t        state;
    logic             mdu_hold;
    logic             load_use;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_hold;
    logic             mem_hold;
    logic [CNT_W-1:0] stall_cnt;

    mdu_timer #(
        .LATENCY (MDU_LATENCY)
    ) u_mdu_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (bus.mdu_start_i),
        .pause_i (bus.mem_stall_i),
        .state_o (state),
        .busy_o  (bus.busy_o)
    );

    assign mdu_hold = (state == ST_MDU_BUSY) || bus.mdu_start_i;
    assign load_use = load_use_hit(bus.ID_EX_MemRead_i, bus.ID_EX_RT_i,
                                   bus.IF_ID_RS_i, bus.IF_ID_RT_i);

    // Reset is folded in so the pipeline free-runs while rst_n_i is low.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        mem_hold     = 1'b0;
        if (rst_n_i) begin
            if (bus.mem_stall_i) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                ex_hold     = 1'b1;
                mem_hold    = 1'b1;
            end else if (mdu_hold) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                ex_hold     = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (bus.branch_taken_i) begin
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt <= '0;
        end else if (bus.stall_cnt_clr_i) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.PC_write_o     = pc_write;
    assign bus.IF_ID_write_o  = if_id_write;
    assign bus.IF_ID_flush_o  = if_id_flush;
    assign bus.ID_EX_bubble_o = id_ex_bubble;
    assign bus.EX_hold_o      = ex_hold;
    assign bus.MEM_hold_o     = mem_hold;
    assign bus.stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a hold-cycle reference model
module tb_hazard_ctrl;

    localparam int LAT  = 4;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) bus();

    hazard_ctrl #(
        .MDU_LATENCY (LAT),
        .CNT_W       (CW)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int m_left = 0;
    int m_cnt  = 0;

    // Control vector order: {PC_write, IF_ID_write, flush, bubble, EX_hold, MEM_hold}
    function automatic logic [5:0] ctrl_now();
        return {bus.PC_write_o, bus.IF_ID_write_o, bus.IF_ID_flush_o,
                bus.ID_EX_bubble_o, bus.EX_hold_o, bus.MEM_hold_o};
    endfunction

    function automatic logic [5:0] model_ctrl();
        logic lu;
        lu = bus.ID_EX_MemRead_i && (bus.ID_EX_RT_i != 0) &&
             ((bus.ID_EX_RT_i == bus.IF_ID_RS_i) || (bus.ID_EX_RT_i == bus.IF_ID_RT_i));
        if (!rst_n)                           return 6'b110000;
        if (bus.mem_stall_i)                  return 6'b000011;
        if ((m_left > 0) || bus.mdu_start_i)  return 6'b000010;
        if (lu)                               return 6'b000100;
        if (bus.branch_taken_i)               return 6'b111000;
        return 6'b110000;
    endfunction

    // m_left counts hold cycles still owed after the issue cycle.
    task automatic model_advance();
        logic [5:0] e;
        e = model_ctrl();
        if (!rst_n) begin
            m_left = 0;
            m_cnt  = 0;
            return;
        end
        if (bus.stall_cnt_clr_i) m_cnt = 0;
        else if (!e[5] && (m_cnt < CMAX)) m_cnt = m_cnt + 1;
        if (!bus.mem_stall_i) begin
            if (m_left > 0) m_left = m_left - 1;
            else if (bus.mdu_start_i) m_left = LAT - 1;
        end
    endtask

    task automatic idle_inputs();
        bus.IF_ID_RS_i      = 5'd0;
        bus.IF_ID_RT_i      = 5'd0;
        bus.ID_EX_RT_i      = 5'd0;
        bus.ID_EX_MemRead_i = 1'b0;
        bus.branch_taken_i  = 1'b0;
        bus.mdu_start_i     = 1'b0;
        bus.mem_stall_i     = 1'b0;
        bus.stall_cnt_clr_i = 1'b0;
    endtask

    task automatic next_cycle();
        model_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        m_left = 0;
        m_cnt  = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.ID_EX_MemRead_i = 1'b1;
        bus.ID_EX_RT_i      = 5'd7;
        bus.IF_ID_RS_i      = 5'd7;
        bus.branch_taken_i  = 1'b1;
        bus.mdu_start_i     = 1'b1;
        bus.mem_stall_i     = 1'b1;
        #1;
        checks++;
        if (ctrl_now() !== 6'b110000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=%b", ctrl_now(), 6'b110000);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy_o);
        end
        checks++;
        if (bus.stall_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ctrl_now() !== 6'b110000 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold ctrl=%b busy=%b exp=110000/0", ctrl_now(), bus.busy_o);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        m_left = 0;
        m_cnt  = 0;
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ID_EX_MemRead_i = 1'b1;
        bus.ID_EX_RT_i      = 5'd5;
        bus.IF_ID_RS_i      = 5'd5;
        bus.IF_ID_RT_i      = 5'd9;
        #1;
        checks++;
        if (ctrl_now() !== 6'b000100) begin
            errors++;
            $display("FAIL load_use_ctrl got=%b exp=%b", ctrl_now(), 6'b000100);
        end
        checks++;
        if (bus.stall_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL load_use_cnt0 got=%0d exp=0", bus.stall_cnt_o);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (bus.stall_cnt_o !== 16'd1 || ctrl_now() !== 6'b110000) begin
            errors++;
            $display("FAIL load_use_after cnt=%0d ctrl=%b exp=1/110000", bus.stall_cnt_o, ctrl_now());
        end
    endtask

    task automatic test_mdu_latency();
        do_reset();
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.mdu_start_i = (cyc == 0);
            #1;
            checks++;
            if (bus.EX_hold_o !== (cyc < 4) || bus.MEM_hold_o !== 1'b0 ||
                bus.PC_write_o !== !(cyc < 4)) begin
                errors++;
                $display("FAIL mdu_hold cyc=%0d ex=%b mem=%b pc=%b exp_ex=%b",
                         cyc, bus.EX_hold_o, bus.MEM_hold_o, bus.PC_write_o, (cyc < 4));
            end
            checks++;
            if (bus.busy_o !== (cyc >= 1 && cyc <= 3)) begin
                errors++;
                $display("FAIL mdu_busy cyc=%0d got=%b exp=%b", cyc, bus.busy_o, (cyc >= 1 && cyc <= 3));
            end
            next_cycle();
        end
        bus.mdu_start_i = 1'b0;
    endtask

    task automatic test_mdu_mem_stall();
        do_reset();
        for (int cyc = 0; cyc < 9; cyc++) begin
            bus.mdu_start_i = (cyc == 0);
            bus.mem_stall_i = (cyc == 2 || cyc == 3);
            #1;
            checks++;
            if (bus.EX_hold_o !== (cyc < 6) || bus.MEM_hold_o !== (cyc == 2 || cyc == 3)) begin
                errors++;
                $display("FAIL mdu_pause cyc=%0d ex=%b mem=%b exp=%b/%b",
                         cyc, bus.EX_hold_o, bus.MEM_hold_o, (cyc < 6), (cyc == 2 || cyc == 3));
            end
            checks++;
            if (bus.busy_o !== (cyc >= 1 && cyc <= 5)) begin
                errors++;
                $display("FAIL mdu_pause_busy cyc=%0d got=%b exp=%b", cyc, bus.busy_o, (cyc >= 1 && cyc <= 5));
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        bus.ID_EX_MemRead_i = 1'b1;
        bus.ID_EX_RT_i      = 5'd12;
        bus.IF_ID_RT_i      = 5'd12;
        bus.branch_taken_i  = 1'b1;
        #1;
        checks++;
        if (ctrl_now() !== 6'b000100) begin
            errors++;
            $display("FAIL lu_beats_branch got=%b exp=%b", ctrl_now(), 6'b000100);
        end
        next_cycle();
        bus.ID_EX_MemRead_i = 1'b0;
        #1;
        checks++;
        if (ctrl_now() !== 6'b111000) begin
            errors++;
            $display("FAIL branch_flush got=%b exp=%b", ctrl_now(), 6'b111000);
        end
        next_cycle();
        bus.ID_EX_MemRead_i = 1'b1;
        bus.mem_stall_i     = 1'b1;
        bus.mdu_start_i     = 1'b1;
        #1;
        checks++;
        if (ctrl_now() !== 6'b000011) begin
            errors++;
            $display("FAIL mem_stall_top got=%b exp=%b", ctrl_now(), 6'b000011);
        end
        next_cycle();
        bus.mdu_start_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || ctrl_now() !== 6'b000011) begin
            errors++;
            $display("FAIL start_during_stall busy=%b ctrl=%b exp=0/000011", bus.busy_o, ctrl_now());
        end
        idle_inputs();
        bus.ID_EX_MemRead_i = 1'b1;
        #1;
        checks++;
        if (ctrl_now() !== 6'b110000) begin
            errors++;
            $display("FAIL zero_reg_load got=%b exp=%b", ctrl_now(), 6'b110000);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        bus.mdu_start_i = 1'b1;
        next_cycle();
        bus.mdu_start_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_pre got=%b exp=1", bus.busy_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.stall_cnt_o !== 16'd0 || ctrl_now() !== 6'b110000) begin
            errors++;
            $display("FAIL mid_busy_reset busy=%b cnt=%0d ctrl=%b exp=0/0/110000",
                     bus.busy_o, bus.stall_cnt_o, ctrl_now());
        end
        @(negedge clk);
        rst_n  = 1'b1;
        m_left = 0;
        m_cnt  = 0;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || ctrl_now() !== 6'b110000) begin
            errors++;
            $display("FAIL post_reset_run busy=%b ctrl=%b exp=0/110000", bus.busy_o, ctrl_now());
        end
        next_cycle();
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.EX_hold_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b ex=%b exp=0/0", bus.busy_o, bus.EX_hold_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bus.IF_ID_RS_i      = 5'($urandom_range(0, 3));
            bus.IF_ID_RT_i      = 5'($urandom_range(0, 3));
            bus.ID_EX_RT_i      = 5'($urandom_range(0, 3));
            bus.ID_EX_MemRead_i = 1'($urandom % 2);
            bus.branch_taken_i  = 1'($urandom % 2);
            bus.mdu_start_i     = ($urandom % 8) == 0;
            bus.mem_stall_i     = ($urandom % 6) == 0;
            bus.stall_cnt_clr_i = ($urandom % 20) == 0;
            #1;
            checks++;
            if (ctrl_now() !== model_ctrl()) begin
                errors++;
                $display("FAIL rand_ctrl n=%0d got=%b exp=%b", n, ctrl_now(), model_ctrl());
            end
            checks++;
            if (bus.busy_o !== (m_left > 0)) begin
                errors++;
                $display("FAIL rand_busy n=%0d got=%b exp=%b", n, bus.busy_o, (m_left > 0));
            end
            checks++;
            if (bus.stall_cnt_o !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, bus.stall_cnt_o, m_cnt);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.mem_stall_i = 1'b1;
        repeat (CMAX) @(negedge clk);
        #1;
        checks++;
        if (bus.stall_cnt_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach got=%0h exp=ffff", bus.stall_cnt_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall_cnt_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got=%0h exp=ffff", bus.stall_cnt_o);
        end
        bus.stall_cnt_clr_i = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall_cnt_o !== 16'h0000) begin
            errors++;
            $display("FAIL sat_clear got=%0h exp=0", bus.stall_cnt_o);
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2;
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_mdu_latency();
        test_mdu_mem_stall();
        test_priority();
        test_reset_mid_busy();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
